pc_fetch: RTL and testbench
===========================

# pc_fetch

Sequential program-counter and instruction-fetch front end that consumes the redirect produced by the next-PC logic: `i_redirect` is fed by that block's `o_PCSrc`, and `i_redirect_pc` by its `o_PC`. It owns the architectural 30-bit word PC and issues one instruction-memory request at a time over a req/ack handshake. It presents the fetched instruction with its PC and PC+1 to decode through a one-entry valid/ready output slot. Wrong-path fetches are squashed on redirect.

## Interface

Parameters:
- `RESET_PC`, default 30'h0000000: word address fetched first after reset.

Ports:
- `i_clk`: in, 1. Clock; all state updates on the rising edge.
- `i_rst`: in, 1. Reset, asynchronous, active-high.
- `i_redirect`: in, 1. Take `i_redirect_pc` as the next fetch PC (from `o_PCSrc`).
- `i_redirect_pc`: in, 30. Redirect target word address (from `o_PC`).
- `o_imem_req`: out, 1. Instruction memory request (registered).
- `o_imem_addr`: out, 30. Word address of the outstanding request (registered).
- `i_imem_ack`: in, 1. Memory accepts the request and returns data in the same cycle.
- `i_imem_data`: in, 32. Instruction word, valid when `i_imem_ack`=1.
- `o_valid`: out, 1. The output slot holds an instruction.
- `o_instr`: out, 32. Held instruction.
- `o_pc`: out, 30. Word address of `o_instr`.
- `o_pc_next`: out, 30. `o_pc`+1 (registered, not combinational), the `i_PC` source for next-PC.
- `i_ready`: in, 1. Decode consumes the slot this cycle when `o_valid`=1.

## Operation

- State: `pc` (next fetch address), FSM {IDLE, REQ, DRAIN}, output slot registers.
- Reset (async, immediate): IDLE, `pc`=RESET_PC, `o_imem_req`=0, `o_imem_addr`=RESET_PC, `o_valid`=0, `o_instr`/`o_pc`/`o_pc_next`=0. An outstanding request is abandoned; memory must tolerate a dropped req.
- Slot free condition `free` = !`o_valid` | `i_ready`.
- IDLE:
  - If `i_redirect`: `pc`<=`i_redirect_pc`, `o_valid`<=0, stay IDLE.
  - Else if `free`: `o_imem_req`<=1, `o_imem_addr`<=`pc`, go to REQ. The slot is cleared if it was consumed.
- REQ (slot is always empty here; one outstanding request maximum):
  - `i_imem_ack` & !`i_redirect`: `o_instr`<=`i_imem_data`, `o_pc`<=`o_imem_addr`, `o_pc_next`<=`o_imem_addr`+1, `o_valid`<=1, `pc`<=`o_imem_addr`+1, `o_imem_req`<=0, go to IDLE.
  - `i_imem_ack` & `i_redirect`: data discarded, `pc`<=`i_redirect_pc`, `o_imem_req`<=0, go to IDLE.
  - !`i_imem_ack` & `i_redirect`: `pc`<=`i_redirect_pc`, go to DRAIN. `o_imem_req` and `o_imem_addr` are held.
  - Neither: hold.
- DRAIN: `o_imem_req` and `o_imem_addr` are held until ack (req/ack rule).
  - On `i_imem_ack`: data discarded, `o_imem_req`<=0, go to IDLE.
  - `i_redirect` in DRAIN: `pc`<=`i_redirect_pc` (last one wins), stay in DRAIN unless ack.
- Redirect priority: `i_redirect` squashes the slot (`o_valid`<=0). `i_ready` is ignored in that cycle.
- Arithmetic: 30-bit unsigned increment, wraps 30'h3FFFFFFF -> 30'h0000000.
- Handshake rule: once `o_imem_req`=1, `o_imem_req` and `o_imem_addr` stay stable until the ack cycle.

## Timing

- Request is issued on the first rising edge after reset release: `o_imem_req`=1, `o_imem_addr`=RESET_PC.
- Zero-wait memory (ack in the first req cycle):
  - Instruction appears in the slot on the edge ending the ack cycle.
  - Steady-state throughput is 1 instruction / 2 cycles with `i_ready`=1.
- Each wait cycle (ack low) adds 1 cycle of latency.
- Redirect-to-request latency:
  - From IDLE or REQ+ack: the target is requested 2 edges later.
  - From REQ without ack: after the drained ack, plus 1 IDLE cycle.
- `o_valid` deasserts on the edge after consumption (`i_ready`=1) unless that same edge captures new data. Capture cannot coincide with a full slot by construction.

## Test plan

- Reset release, ack always 1, `i_ready`=1, RESET_PC=30'h10 -> `o_imem_addr` sequence 10,11,12 every 2 cycles; `o_pc`/`o_pc_next` = 10/11, 11/12; `o_instr` matches the memory model.
- `i_ready`=0 for 5 cycles with slot full -> no new req, `o_instr`/`o_pc` stable. Then `i_ready`=1 -> next req at `o_pc`+1.
- Redirect to 30'h200 while REQ with ack held low 3 cycles -> req/addr unchanged until ack, data discarded, `o_valid` stays 0, next req addr 30'h200.
- Redirect to 30'h40 on the same cycle as ack -> fetched word dropped, next req addr 30'h40. Separately: redirect with slot full and `i_ready`=1 -> slot squashed, nothing delivered.
- Two redirects in DRAIN (30'h80 then 30'h90) -> after ack, fetch 30'h90.
- RESET_PC=30'h3FFFFFFF -> second fetch addr 30'h0, `o_pc_next` of the first instruction = 0. Assert `i_rst` mid-REQ -> `o_imem_req` drops immediately, `o_valid`=0, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pc_fetch_if.sv
// Bundle of the redirect, instruction-memory and decode-slot signals of the fetch front end.
// The master modport is the fetch unit; the slave modport is its surroundings.
interface pc_fetch_if;
  logic        i_redirect;
  logic [29:0] i_redirect_pc;
  logic        o_imem_req;
  logic [29:0] o_imem_addr;
  logic        i_imem_ack;
  logic [31:0] i_imem_data;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [29:0] o_pc;
  logic [29:0] o_pc_next;
  logic        i_ready;

  modport master (
    input  i_redirect, i_redirect_pc, i_imem_ack, i_imem_data, i_ready,
    output o_imem_req, o_imem_addr, o_valid, o_instr, o_pc, o_pc_next
  );

  modport slave (
    output i_redirect, i_redirect_pc, i_imem_ack, i_imem_data, i_ready,
    input  o_imem_req, o_imem_addr, o_valid, o_instr, o_pc, o_pc_next
  );
endinterface

// File: rtl/pc_fetch.sv
// Program counter and single-outstanding instruction fetch with a one-entry decode slot.
// Redirects squash the slot and any in-flight fetch; a request already issued is drained before refetch.
module pc_fetch #(
  parameter logic [29:0] RESET_PC = 30'h0000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  pc_fetch_if.master  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]  state;
  logic [29:0] pc;
  logic        req;
  logic [29:0] addr;
  logic        valid;
  logic [31:0] instr;
  logic [29:0] slot_pc;
  logic [29:0] slot_pc_next;
  logic        free;

  function automatic logic [29:0] inc30(input logic [29:0] a);
    return a + 30'd1;
  endfunction

  assign free = !valid || bus.i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      req          <= 1'b0;
      addr         <= RESET_PC;
      valid        <= 1'b0;
      instr        <= 32'd0;
      slot_pc      <= 30'd0;
      slot_pc_next <= 30'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_redirect) begin
            pc    <= bus.i_redirect_pc;
            valid <= 1'b0;
          end else if (free) begin
            req   <= 1'b1;
            addr  <= pc;
            valid <= 1'b0;
            state <= REQ;
          end
        end
        // Slot is empty here, so a capture can never overwrite an unconsumed instruction.
        REQ: begin
          if (bus.i_imem_ack && !bus.i_redirect) begin
            instr        <= bus.i_imem_data;
            slot_pc      <= addr;
            slot_pc_next <= inc30(addr);
            valid        <= 1'b1;
            pc           <= inc30(addr);
            req          <= 1'b0;
            state        <= IDLE;
          end else if (bus.i_imem_ack) begin
            pc    <= bus.i_redirect_pc;
            req   <= 1'b0;
            valid <= 1'b0;
            state <= IDLE;
          end else if (bus.i_redirect) begin
            pc    <= bus.i_redirect_pc;
            valid <= 1'b0;
            state <= DRAIN;
          end
        end
        // Wrong-path request must still complete its handshake; its data is thrown away.
        DRAIN: begin
          if (bus.i_redirect) begin
            pc    <= bus.i_redirect_pc;
            valid <= 1'b0;
          end
          if (bus.i_imem_ack) begin
            req   <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          req   <= 1'b0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_imem_req  = req;
  assign bus.o_imem_addr = addr;
  assign bus.o_valid     = valid;
  assign bus.o_instr     = instr;
  assign bus.o_pc        = slot_pc;
  assign bus.o_pc_next   = slot_pc_next;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: sequencing, back-pressure, redirects, drain, PC wrap and async reset.
module tb_pc_fetch;

  logic clk;
  logic rst;

  pc_fetch_if bus_a ();
  pc_fetch_if bus_b ();

  pc_fetch #(.RESET_PC(30'h10)) dut_a (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_a.master)
  );

  pc_fetch #(.RESET_PC(30'h3FFFFFFF)) dut_b (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_b.master)
  );

  int n_checks;
  int n_fail;

  function automatic logic [31:0] mem_word(input logic [29:0] a);
    return {a, 2'b01} ^ 32'hDEAD_BEEF;
  endfunction

  assign bus_a.i_imem_data = mem_word(bus_a.o_imem_addr);
  assign bus_b.i_imem_data = mem_word(bus_b.o_imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    rst                 = 1'b1;
    bus_a.i_redirect    = 1'b0;
    bus_a.i_redirect_pc = 30'h0;
    bus_a.i_imem_ack    = 1'b1;
    bus_a.i_ready       = 1'b1;
    bus_b.i_redirect    = 1'b0;
    bus_b.i_redirect_pc = 30'h0;
    bus_b.i_imem_ack    = 1'b1;
    bus_b.i_ready       = 1'b1;

    @(negedge clk);
    @(negedge clk);
    check_eq("rst_req",     32'(bus_a.o_imem_req),  32'd0);
    check_eq("rst_addr",    32'(bus_a.o_imem_addr), 32'h10);
    check_eq("rst_valid",   32'(bus_a.o_valid),     32'd0);
    check_eq("rst_instr",   bus_a.o_instr,          32'd0);
    check_eq("rst_pc",      32'(bus_a.o_pc),        32'd0);
    check_eq("rst_pc_next", 32'(bus_a.o_pc_next),   32'd0);
    check_eq("rst_b_addr",  32'(bus_b.o_imem_addr), 32'h3FFFFFFF);

    // Zero-wait sequencing from RESET_PC
    rst = 1'b0;
    tick();
    check_eq("seq_req0",   32'(bus_a.o_imem_req),  32'd1);
    check_eq("seq_addr0",  32'(bus_a.o_imem_addr), 32'h10);
    check_eq("seq_vld0",   32'(bus_a.o_valid),     32'd0);
    tick();
    check_eq("seq_req_lo", 32'(bus_a.o_imem_req),  32'd0);
    check_eq("seq_vld1",   32'(bus_a.o_valid),     32'd1);
    check_eq("seq_pc0",    32'(bus_a.o_pc),        32'h10);
    check_eq("seq_pcn0",   32'(bus_a.o_pc_next),   32'h11);
    check_eq("seq_instr0", bus_a.o_instr,          32'h0000_0041 ^ 32'hDEAD_BEEF);
    check_eq("wrap_b_pc",  32'(bus_b.o_pc),        32'h3FFFFFFF);
    check_eq("wrap_b_pcn", 32'(bus_b.o_pc_next),   32'h0);
    tick();
    check_eq("seq_addr1",  32'(bus_a.o_imem_addr), 32'h11);
    check_eq("seq_vld2",   32'(bus_a.o_valid),     32'd0);
    check_eq("wrap_b_addr", 32'(bus_b.o_imem_addr), 32'h0);
    check_eq("wrap_b_req", 32'(bus_b.o_imem_req),  32'd1);
    tick();
    check_eq("seq_pc1",    32'(bus_a.o_pc),        32'h11);
    check_eq("seq_pcn1",   32'(bus_a.o_pc_next),   32'h12);
    check_eq("seq_instr1", bus_a.o_instr,          32'h0000_0045 ^ 32'hDEAD_BEEF);

    // Back-pressure with a full slot
    bus_a.i_ready = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_eq("bp_req",   32'(bus_a.o_imem_req), 32'd0);
    check_eq("bp_valid", 32'(bus_a.o_valid),    32'd1);
    check_eq("bp_pc",    32'(bus_a.o_pc),       32'h11);
    check_eq("bp_instr", bus_a.o_instr,         32'h0000_0045 ^ 32'hDEAD_BEEF);
    bus_a.i_ready = 1'b1;
    tick();
    check_eq("bp_rel_req",  32'(bus_a.o_imem_req),  32'd1);
    check_eq("bp_rel_addr", 32'(bus_a.o_imem_addr), 32'h12);
    check_eq("bp_rel_vld",  32'(bus_a.o_valid),     32'd0);

    // Redirect while waiting for ack: drain, then fetch target
    bus_a.i_imem_ack    = 1'b0;
    bus_a.i_redirect    = 1'b1;
    bus_a.i_redirect_pc = 30'h200;
    tick();
    bus_a.i_redirect = 1'b0;
    check_eq("drn_req0",  32'(bus_a.o_imem_req),  32'd1);
    check_eq("drn_addr0", 32'(bus_a.o_imem_addr), 32'h12);
    tick();
    tick();
    check_eq("drn_req2",  32'(bus_a.o_imem_req),  32'd1);
    check_eq("drn_addr2", 32'(bus_a.o_imem_addr), 32'h12);
    bus_a.i_imem_ack = 1'b1;
    tick();
    check_eq("drn_done_req", 32'(bus_a.o_imem_req), 32'd0);
    check_eq("drn_done_vld", 32'(bus_a.o_valid),    32'd0);
    tick();
    check_eq("drn_tgt_req",  32'(bus_a.o_imem_req),  32'd1);
    check_eq("drn_tgt_addr", 32'(bus_a.o_imem_addr), 32'h200);
    tick();
    check_eq("drn_tgt_pc",  32'(bus_a.o_pc),    32'h200);
    check_eq("drn_tgt_vld", 32'(bus_a.o_valid), 32'd1);
    tick();
    check_eq("next_addr", 32'(bus_a.o_imem_addr), 32'h201);

    // Redirect coinciding with ack
    bus_a.i_redirect    = 1'b1;
    bus_a.i_redirect_pc = 30'h40;
    tick();
    bus_a.i_redirect = 1'b0;
    check_eq("rack_req", 32'(bus_a.o_imem_req), 32'd0);
    check_eq("rack_vld", 32'(bus_a.o_valid),    32'd0);
    tick();
    check_eq("rack_addr", 32'(bus_a.o_imem_addr), 32'h40);
    tick();
    check_eq("rack_pc",  32'(bus_a.o_pc),    32'h40);
    check_eq("rack_vld2", 32'(bus_a.o_valid), 32'd1);

    // Redirect with a full slot and ready high squashes it
    bus_a.i_redirect    = 1'b1;
    bus_a.i_redirect_pc = 30'h300;
    tick();
    bus_a.i_redirect = 1'b0;
    check_eq("sq_vld", 32'(bus_a.o_valid),    32'd0);
    check_eq("sq_req", 32'(bus_a.o_imem_req), 32'd0);
    tick();
    check_eq("sq_addr", 32'(bus_a.o_imem_addr), 32'h300);
    check_eq("sq_vld2", 32'(bus_a.o_valid),     32'd0);

    // Two redirects during drain: last one wins
    bus_a.i_imem_ack    = 1'b0;
    bus_a.i_redirect    = 1'b1;
    bus_a.i_redirect_pc = 30'h80;
    tick();
    bus_a.i_redirect_pc = 30'h90;
    tick();
    bus_a.i_redirect = 1'b0;
    check_eq("dd_addr", 32'(bus_a.o_imem_addr), 32'h300);
    bus_a.i_imem_ack = 1'b1;
    tick();
    check_eq("dd_req", 32'(bus_a.o_imem_req), 32'd0);
    tick();
    check_eq("dd_tgt", 32'(bus_a.o_imem_addr), 32'h90);

    // Async reset mid-request
    bus_a.i_imem_ack = 1'b0;
    tick();
    check_eq("mr_req_pre", 32'(bus_a.o_imem_req), 32'd1);
    #1 rst = 1'b1;
    #1;
    check_eq("mr_req",  32'(bus_a.o_imem_req),  32'd0);
    check_eq("mr_vld",  32'(bus_a.o_valid),     32'd0);
    check_eq("mr_addr", 32'(bus_a.o_imem_addr), 32'h10);
    @(negedge clk);
    rst = 1'b0;
    bus_a.i_imem_ack = 1'b1;
    tick();
    check_eq("mr_restart_req",  32'(bus_a.o_imem_req),  32'd1);
    check_eq("mr_restart_addr", 32'(bus_a.o_imem_addr), 32'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
